// File: rtl/dm_store_buffer.sv
// dm_store_buffer: circular store FIFO between the core data port and dmem, with youngest-match load forwarding
module dm_store_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  output logic [N-1:0] DM_readData,
  output logic         stall,
  output logic         mem_write,
  output logic         mem_read,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [N-4:0]    tag_q  [DEPTH];
  logic [N-1:0]    data_q [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]   count_q, count_d;
  logic            hit, load_miss, pop, push, full;
  logic [N-1:0]    fwd;
  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (CW'(k) < count_q && tag_q[idx] == DM_addr[N-1:3]) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end
  assign load_miss   = DM_readEnable & ~hit;
  assign full        = count_q == CW'(DEPTH);
  assign pop         = (count_q != '0) & mem_ready & ~load_miss;
  assign push        = DM_writeEnable & (~full | pop);
  assign stall       = DM_writeEnable & full & ~pop;
  assign empty       = count_q == '0;
  assign mem_write   = pop;
  assign mem_read    = load_miss;
  assign mem_addr    = load_miss ? DM_addr : pop ? {tag_q[head_q], 3'b000} : '0;
  assign mem_wdata   = pop ? data_q[head_q] : '0;
  assign DM_readData = (DM_readEnable & hit) ? fwd : mem_rdata;
  assign head_d      = head_q + AW'(pop);
  assign tail_d      = tail_q + AW'(push);
  assign count_d     = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry payloads need no reset: validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= DM_addr[N-1:3];
      data_q[tail_q] <= DM_writeData;
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed and random stimulus checked against a queue model of the store buffer
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  typedef struct {logic [60:0] tag; logic [63:0] data;} ent_t;
  typedef struct {logic [63:0] addr; logic [63:0] data;} wr_t;
  logic clk = 1'b0, reset = 1'b0;
  logic we = 1'b0, re = 1'b0, mem_ready = 1'b0;
  logic [63:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic [63:0] DM_readData, mem_addr, mem_wdata;
  logic stall, mem_write, mem_read, empty;
  int checks = 0, errors = 0;
  ent_t q[$];
  wr_t wlog[$];
  logic e_pop, e_push, e_stall;
  logic [63:0] p_addr, p_data;

  dm_store_buffer #(.N(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .DM_writeEnable(we), .DM_readEnable(re),
    .DM_addr(addr), .DM_writeData(wdata), .DM_readData(DM_readData),
    .stall(stall), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  // Drive one cycle's inputs and compare every output with the queue model.
  task automatic drive(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                       input logic rdy, input logic [63:0] rd);
    logic hit, miss;
    logic [63:0] fd;
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d; mem_ready = rdy; mem_rdata = rd;
    #1;
    hit = 1'b0;
    fd = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!hit && q[i].tag == a[63:3]) begin
        hit = 1'b1;
        fd = q[i].data;
      end
    hit = hit & r;
    miss = r & ~hit;
    e_pop = q.size() > 0 && rdy && !miss;
    e_stall = w && q.size() == DEPTH && !e_pop;
    e_push = w && !e_stall;
    p_addr = a;
    p_data = d;
    chk("stall", 64'(stall), 64'(e_stall));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("mem_write", 64'(mem_write), 64'(e_pop));
    chk("mem_read", 64'(mem_read), 64'(miss));
    chk("mem_addr", mem_addr, miss ? a : e_pop ? {q[0].tag, 3'b000} : 64'd0);
    chk("mem_wdata", mem_wdata, e_pop ? q[0].data : 64'd0);
    chk("rdata", DM_readData, hit ? fd : rd);
    if (mem_write) wlog.push_back('{mem_addr, mem_wdata});
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_push) q.push_back('{p_addr[63:3], p_data});
  endtask

  task automatic step(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                      input logic rdy, input logic [63:0] rd);
    drive(w, r, a, d, rdy, rd);
    tick();
  endtask

  initial begin
    logic [63:0] a, d;
    int op, i, n;
    logic held;
    // Stores during reset are ignored.
    @(negedge clk);
    we = 1'b1; addr = 64'h8; wdata = 64'h55; mem_ready = 1'b1; mem_rdata = 64'hABCD;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_rdata", DM_readData, 64'hABCD);
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    chk("post_rst_empty", 64'(empty), 64'd1);
    tick();
    // Basic drain
    step(1, 0, 64'h08, 64'h1111, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("drain_we", 64'(mem_write), 64'd1);
    chk("drain_addr", mem_addr, 64'h08);
    chk("drain_data", mem_wdata, 64'h1111);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    chk("drain_empty", 64'(empty), 64'd1);
    tick();
    // Forwarding picks the youngest store
    step(1, 0, 64'h10, 64'hA, 0, 0);
    step(1, 0, 64'h10, 64'hB, 0, 0);
    drive(0, 1, 64'h10, 0, 0, 64'hDEAD);
    chk("fwd_data", DM_readData, 64'hB);
    chk("fwd_noread", 64'(mem_read), 64'd0);
    tick();
    drive(0, 1, 64'h18, 0, 0, 64'hBEEF);
    chk("miss_read", 64'(mem_read), 64'd1);
    chk("miss_data", DM_readData, 64'hBEEF);
    tick();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
    // Full and stall
    for (int k = 0; k < 4; k++) step(1, 0, 64'h20 + 64'(k * 8), 64'h100 + 64'(k), 0, 0);
    drive(1, 0, 64'h60, 64'h5, 0, 0);
    chk("full_stall", 64'(stall), 64'd1);
    tick();
    drive(1, 0, 64'h60, 64'h5, 1, 0);
    chk("full_unstall", 64'(stall), 64'd0);
    tick();
    drive(1, 0, 64'h68, 64'h6, 0, 0);
    chk("full_count4", 64'(stall), 64'd1);
    tick();
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1, 0);
    // Load miss blocks the drain for one cycle
    step(1, 0, 64'h40, 64'h77, 0, 0);
    drive(0, 1, 64'h48, 0, 1, 64'h1234);
    chk("lm_nowrite", 64'(mem_write), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    chk("lm_resume", 64'(mem_write), 64'd1);
    chk("lm_head", mem_addr, 64'h40);
    tick();
    // Ten distinct stores through the wrapping FIFO must reach dmem in order
    wlog.delete();
    i = 0;
    n = 0;
    while (i < 10 && n < 200) begin
      drive(1, 0, 64'h1000 + 64'(i * 8), 64'hC0 + 64'(i), 1'($urandom_range(0, 1)), 0);
      if (!e_stall) i++;
      tick();
      n++;
    end
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 0);
    chk("wrap_count", 64'(wlog.size()), 64'd10);
    for (int k = 0; k < 10 && k < wlog.size(); k++) begin
      chk("wrap_addr", wlog[k].addr, 64'h1000 + 64'(k * 8));
      chk("wrap_data", wlog[k].data, 64'hC0 + 64'(k));
    end
    // Reset mid-run discards queued stores
    for (int k = 0; k < 3; k++) step(1, 0, 64'h200 + 64'(k * 8), 64'h9 + 64'(k), 0, 0);
    @(negedge clk);
    we = 1'b0; mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_nowrite", 64'(mem_write), 64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    wlog.delete();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);
    chk("mid_rst_nodrain", 64'(wlog.size()), 64'd0);
    // Random traffic; a stalled store is re-presented unchanged
    held = 1'b0;
    a = '0;
    d = '0;
    for (int k = 0; k < 400; k++) begin
      if (!held) begin
        op = $urandom_range(0, 2);
        a = 64'h4000 + (64'($urandom_range(0, 7)) << 3) + 64'($urandom_range(0, 7));
        d = {$urandom, $urandom};
      end
      drive(op == 1, op == 2, a, d, 1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
      held = e_stall;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer between the pipelined core's MEM-stage data port and `dmem`. It queues stores issued by the core and drains them to `dmem` one per cycle whenever the memory is ready and the port is not needed for a load. Loads are forwarded from the youngest matching buffered store, so program order is preserved. The block back-pressures the core with `stall` when a store arrives while the buffer is full and cannot drain.

## Interface
Parameters:
- `N`, 64: data/address width.
- `DEPTH`, 4: number of buffer entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; state clears while `reset` = 0.
- `DM_writeEnable`  in  1  core store request (MEM stage).
- `DM_readEnable`  in  1  core load request (MEM stage).
- `DM_addr`  in  N  byte address; the doubleword tag is `DM_addr[N-1:3]`.
- `DM_writeData`  in  N  store data.
- `DM_readData`  out  N  load data returned to the core (combinational).
- `stall`  out  1  core must hold its MEM stage this cycle.
- `mem_write`  out  1  write strobe to `dmem`.
- `mem_read`  out  1  read strobe to `dmem`.
- `mem_addr`  out  N  address to `dmem`.
- `mem_wdata`  out  N  write data to `dmem`.
- `mem_rdata`  in  N  `dmem` asynchronous read data.
- `mem_ready`  in  1  `dmem` accepts a write this cycle.
- `empty`  out  1  buffer holds no entries; used to gate `dump`.

## Operation
- Storage: `DEPTH` entries of {tag, data}, organized as a circular FIFO.
  - Pointers: `head` and `tail`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy: `count`, width $clog2(DEPTH+1), ranging 0..DEPTH.
- Load hit:
  - Condition: `DM_readEnable` = 1 and any valid entry's tag equals `DM_addr[N-1:3]`.
  - Action: `DM_readData` = data of the youngest matching entry, found by searching from `tail-1` back toward `head`.
  - The port is not used: `mem_read` = 0.
- Load miss:
  - Action: `mem_read` = 1, `mem_addr` = `DM_addr`, `DM_readData` = `mem_rdata`.
  - The drain is suppressed this cycle.
- Drain (`pop`):
  - Condition: `count` > 0, `mem_ready` = 1, and no load miss this cycle.
  - Outputs: `mem_write` = 1, `mem_addr` = {head tag, 3'b000}, `mem_wdata` = head data.
  - On the clock edge, `head` increments.
- Store accept (`push`):
  - Condition: `DM_writeEnable` = 1 and (`count` < DEPTH or `pop`).
  - On the clock edge, the entry is written at `tail` and `tail` increments.
- Stall: `stall` = `DM_writeEnable` & (`count` == DEPTH) & ~`pop`.
  - A stalled store is not written.
  - The core re-presents the same store the next cycle.
- Count update: `count` += `push` − `pop`. Simultaneous push and pop leaves `count` unchanged, including when full.
- Load and store in the same cycle are illegal from the core and are not handled.
- Idle outputs: when neither drain nor load miss is active, `mem_write` = `mem_read` = 0 and `mem_addr` = `mem_wdata` = 0.
- `empty` = (`count` == 0).

## Timing
- Reset (`reset` = 0, asynchronous):
  - `head` = `tail` = `count` = 0 and all entries are invalid.
  - Resulting outputs: `empty` = 1, `stall` = 0, `mem_write` = 0, `mem_read` = 0, `DM_readData` = `mem_rdata`.
- Reset asserted mid-operation discards all buffered stores. No drain completes after the asserting edge.
- Store latency: the accepted store is visible to load forwarding from the cycle after the accept edge. The earliest drain is that same next cycle.
- Load latency: 0 cycles in both cases (combinational forward or pass-through). No stall is ever raised for loads.
- Full with `mem_ready` = 0: `stall` stays high until the first cycle with `mem_ready` = 1 and no load miss.
- Pointer wrap: after entry DEPTH−1, `tail`/`head` return to 0. Forwarding search must respect the wrap.
- Drain order is strict FIFO. Repeated stores to one tag are all written to `dmem` in order; there is no coalescing.

## Test plan
- Reset: hold `reset` = 0 while driving stores → `empty` = 1, `mem_write` = 0, `stall` = 0. After release, `count` = 0.
- Basic drain: store 0x1111 to addr 0x08 with `mem_ready` = 1 → next cycle `mem_write` = 1, `mem_addr` = 0x08, `mem_wdata` = 0x1111. The cycle after that, `empty` = 1.
- Forwarding:
  - Setup: `mem_ready` = 0; store 0xA to 0x10, then 0xB to 0x10.
  - Load 0x10 → `DM_readData` = 0xB, `mem_read` = 0.
  - Load 0x18 → `mem_read` = 1, `DM_readData` = `mem_rdata`.
- Full and stall:
  - `mem_ready` = 0 with 4 stores queued; a 5th store → `stall` = 1, `count` = 4.
  - Raise `mem_ready` → `stall` = 0 the same cycle; the store is accepted and `count` stays 4.
- Load miss priority: buffer non-empty, `mem_ready` = 1, load miss issued → `mem_write` = 0 that cycle and `head` unchanged. The drain resumes the next cycle.
- Wrap and reset mid-run:
  - 10 stores to distinct tags with `mem_ready` toggling → `dmem` receives all 10 in issue order.
  - Asserting `reset` with 3 entries queued → `empty` = 1 immediately, and no further `mem_write` occurs.
